// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a MEM-stage memory instruction into a single
// bus transaction on a split address/data handshake, and stalls the pipeline
// until the transaction completes. Loads are lane-extracted and extended here,
// and stores are lane-replicated here.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemSignedM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   input  logic        StallM,
   output logic [31:0] ReadDataM,
   output logic        StallReqM,
   output logic        AdelM,
   output logic        AdesM,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic [31:0] data_rdata,
   input  logic        data_data_ok
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t state, state_next;

   logic        is_word;
   logic [1:0]  size_norm;
   logic        misaligned;
   logic        pending;
   logic        start;
   logic        capture;
   logic [31:0] wdata_rep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   logic        req_wr;
   logic        req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   // Size 11 behaves as a word, so it is folded to 10 before anything uses it.
   assign is_word    = MemSizeM[1];
   assign size_norm  = is_word ? 2'b10 : MemSizeM;
   assign misaligned = ((MemSizeM == 2'b01) & AddrM[0]) |
                       (is_word & (AddrM[1:0] != 2'b00));
   assign pending    = (MemReadM | MemWriteM) & ~misaligned;

   assign AdelM = MemReadM & misaligned;
   assign AdesM = MemWriteM & misaligned;

   assign data_wr    = req_wr;
   assign data_size  = req_size;
   assign data_addr  = req_addr;
   assign data_wdata = req_wdata;

   // Replicate store data onto every lane so the bus can pick any byte lane.
   always_comb begin
      wdata_rep = WriteDataM;
      case (size_norm)
         2'b00:   wdata_rep = {4{WriteDataM[7:0]}};
         2'b01:   wdata_rep = {2{WriteDataM[15:0]}};
         default: wdata_rep = WriteDataM;
      endcase
   end

   // Pick the addressed lane out of the returned word and extend it to 32 bits.
   always_comb begin
      byte_sel = data_rdata[7:0];
      case (req_addr[1:0])
         2'b00:   byte_sel = data_rdata[7:0];
         2'b01:   byte_sel = data_rdata[15:8];
         2'b10:   byte_sel = data_rdata[23:16];
         default: byte_sel = data_rdata[31:24];
      endcase
      half_sel = req_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
      load_ext = data_rdata;
      case (req_size)
         2'b00:   load_ext = {{24{req_signed & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{req_signed & half_sel[15]}}, half_sel};
         default: load_ext = data_rdata;
      endcase
   end

   // Next-state and handshake decode; stray addr_ok/data_ok are ignored outside
   // the states that wait for them.
   always_comb begin
      state_next = state;
      StallReqM  = 1'b0;
      data_req   = 1'b0;
      start      = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               start      = 1'b1;
               StallReqM  = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            data_req  = 1'b1;
            StallReqM = 1'b1;
            if (data_addr_ok) begin
               if (data_data_ok) begin
                  capture    = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            StallReqM = 1'b1;
            if (data_data_ok) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (!StallM) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request registers hold the bus request stable for the whole handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_wr     <= 1'b0;
         req_signed <= 1'b0;
         req_size   <= 2'b00;
         req_addr   <= 32'h0;
         req_wdata  <= 32'h0;
      end else if (start) begin
         req_wr     <= MemWriteM;
         req_signed <= MemSignedM;
         req_size   <= size_norm;
         req_addr   <= AddrM;
         req_wdata  <= wdata_rep;
      end
   end

   // Result register; stores complete with a zero result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ReadDataM <= 32'h0;
      end else if (capture) begin
         ReadDataM <= req_wr ? 32'h0 : load_ext;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus
// requests and results into queues, independent monitors pop and compare.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        MemReadM;
   logic        MemWriteM;
   logic [1:0]  MemSizeM;
   logic        MemSignedM;
   logic [31:0] AddrM;
   logic [31:0] WriteDataM;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        StallReqM;
   logic        AdelM;
   logic        AdesM;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic [31:0] data_rdata;
   logic        data_data_ok;

   int total = 0;
   int bad   = 0;

   logic [66:0] bus_q[$];
   logic [31:0] res_q[$];

   mem_access_unit dut (
      .clk          (clk),
      .rst          (rst),
      .MemReadM     (MemReadM),
      .MemWriteM    (MemWriteM),
      .MemSizeM     (MemSizeM),
      .MemSignedM   (MemSignedM),
      .AddrM        (AddrM),
      .WriteDataM   (WriteDataM),
      .StallM       (StallM),
      .ReadDataM    (ReadDataM),
      .StallReqM    (StallReqM),
      .AdelM        (AdelM),
      .AdesM        (AdesM),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_rdata   (data_rdata),
      .data_data_ok (data_data_ok)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] time limit reached");
   end

   function automatic void check_output(input string name, input logic [66:0] act,
                                        input logic [66:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endfunction

   // Bus monitor: every accepted request must match the oldest expected one.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && data_req && data_addr_ok) begin
            if (bus_q.size() == 0) begin
               check_output("bus_unexpected", {data_wr, data_size, data_addr, data_wdata}, 67'h0);
            end else begin
               check_output("bus_request", {data_wr, data_size, data_addr, data_wdata},
                            bus_q.pop_front());
            end
         end
      end
   end

   // Result monitor: the cycle the stall drops after stalling is the completion cycle.
   initial begin
      logic prev_stall;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !StallReqM) begin
               if (res_q.size() == 0) begin
                  check_output("result_unexpected", {35'h0, ReadDataM}, 67'h7_FFFF_FFFF_FFFF_FFFF);
               end else begin
                  check_output("result", {35'h0, ReadDataM}, {35'h0, res_q.pop_front()});
               end
            end
            prev_stall = StallReqM;
         end
      end
   end

   task automatic clear_inputs();
      MemReadM     = 1'b0;
      MemWriteM    = 1'b0;
      MemSizeM     = 2'b00;
      MemSignedM   = 1'b0;
      AddrM        = 32'h0;
      WriteDataM   = 32'h0;
      StallM       = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h5A5A5A5A;
   endtask

   // One aligned access with a scripted bus: addr_ok after addr_delay REQ
   // cycles, data_ok data_delay cycles later, then stall_cycles of StallM in DONE.
   task automatic apply_stimulus(input string name, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int addr_delay,
                                 input int data_delay, input int stall_cycles,
                                 input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_result);
      int ca, cd, last, req_cnt, stall_cnt, unstable;
      ca = 1 + addr_delay;
      cd = ca + data_delay;
      last = cd + 1 + stall_cycles;
      req_cnt = 0;
      stall_cnt = 0;
      unstable = 0;
      bus_q.push_back({wr, exp_size, addr, exp_wdata});
      res_q.push_back(exp_result);
      for (int c = 0; c <= last; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            MemReadM   = rd;
            MemWriteM  = wr;
            MemSizeM   = size;
            MemSignedM = sgn;
            AddrM      = addr;
            WriteDataM = wdata;
         end
         data_addr_ok = (c == ca);
         data_data_ok = (c == cd);
         data_rdata   = (c == cd) ? rdata : 32'h5A5A5A5A;
         StallM       = (c > cd) && (c < last);
         @(negedge clk);
         if (data_req) begin
            req_cnt++;
            if (data_wr !== wr || data_size !== exp_size || data_addr !== addr ||
                data_wdata !== exp_wdata) begin
               unstable++;
            end
         end
         if (StallReqM) stall_cnt++;
         if (c > cd) begin
            check_output({name, "_done_hold"}, {34'h0, data_req, ReadDataM}, {35'h0, exp_result});
         end
      end
      @(posedge clk);
      #1;
      clear_inputs();
      check_output({name, "_req_cycles"}, 67'(req_cnt), 67'(addr_delay + 1));
      check_output({name, "_stall_cycles"}, 67'(stall_cnt), 67'(2 + addr_delay + data_delay));
      check_output({name, "_req_stable"}, 67'(unstable), 67'h0);
   endtask

   // A misaligned access must flag an exception and never reach the bus.
   task automatic misaligned_access(input string name, input logic rd, input logic wr,
                                    input logic [1:0] size, input logic [31:0] addr,
                                    input logic exp_adel, input logic exp_ades);
      @(posedge clk);
      #1;
      MemReadM  = rd;
      MemWriteM = wr;
      MemSizeM  = size;
      AddrM     = addr;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_output(name, {63'h0, AdelM, AdesM, data_req, StallReqM},
                      {63'h0, exp_adel, exp_ades, 1'b0, 1'b0});
         @(posedge clk);
         #1;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #12;
      check_output("reset_state", {32'h0, data_req, StallReqM, AdelM, ReadDataM},
                   {32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
      @(posedge clk);
      #1;
      rst = 1'b1;

      // lw with single-cycle handshake, held in DONE by StallM for 3 cycles
      apply_stimulus("lw_fast", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h12345678,
                     0, 0, 3, 2'b10, 32'h0, 32'h12345678);
      apply_stimulus("lb_signed", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFFFF,
                     0, 0, 0, 2'b00, 32'h0, 32'hFFFFFF80);
      apply_stimulus("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FFFFFF,
                     0, 0, 0, 2'b00, 32'h0, 32'h00000080);
      apply_stimulus("sh_slow", 0, 1, 2'b01, 0, 32'h202, 32'hAAAABEEF, 32'h5A5A5A5A,
                     3, 2, 0, 2'b01, 32'hBEEFBEEF, 32'h0);
      apply_stimulus("lh_signed", 1, 0, 2'b01, 1, 32'h206, 32'h0, 32'h80017FFF,
                     1, 1, 0, 2'b01, 32'h0, 32'hFFFF8001);
      apply_stimulus("sb", 0, 1, 2'b00, 0, 32'h301, 32'h123456A5, 32'h5A5A5A5A,
                     0, 1, 1, 2'b00, 32'hA5A5A5A5, 32'h0);
      apply_stimulus("lhu", 1, 0, 2'b01, 0, 32'h300, 32'h0, 32'h1234F00D,
                     2, 0, 0, 2'b01, 32'h0, 32'h0000F00D);
      apply_stimulus("rd_wr_store", 1, 1, 2'b10, 0, 32'h108, 32'hDEADBEEF, 32'h5A5A5A5A,
                     0, 0, 0, 2'b10, 32'hDEADBEEF, 32'h0);
      apply_stimulus("lw_size11", 1, 0, 2'b11, 0, 32'h104, 32'h0, 32'hCAFEBABE,
                     0, 0, 0, 2'b10, 32'h0, 32'hCAFEBABE);

      misaligned_access("adel_lw", 1, 0, 2'b10, 32'h102, 1'b1, 1'b0);
      misaligned_access("ades_sw", 0, 1, 2'b10, 32'h101, 1'b0, 1'b1);
      misaligned_access("ades_sh", 0, 1, 2'b01, 32'h201, 1'b0, 1'b1);

      // Reset while waiting for data: the late data_ok must be ignored.
      @(posedge clk);
      #1;
      MemReadM = 1'b1;
      MemSizeM = 2'b10;
      AddrM    = 32'h400;
      bus_q.push_back({1'b0, 2'b10, 32'h400, 32'h0});
      @(posedge clk);
      #1;
      data_addr_ok = 1'b1;
      @(posedge clk);
      #1;
      data_addr_ok = 1'b0;
      @(negedge clk);
      check_output("wait_state", {65'h0, data_req, StallReqM}, {65'h0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_output("reset_pending_stall", {66'h0, StallReqM}, {66'h0, 1'b1});
      MemReadM = 1'b0;
      @(negedge clk);
      check_output("reset_mid_txn", {33'h0, data_req, StallReqM, ReadDataM},
                   {33'h0, 1'b0, 1'b0, 32'h0});
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      data_data_ok = 1'b1;
      data_rdata   = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      data_data_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_output("late_data_ok", {33'h0, data_req, StallReqM, ReadDataM},
                      {33'h0, 1'b0, 1'b0, 32'h0});
      end

      repeat (2) @(posedge clk);
      check_output("bus_queue_empty", 67'(bus_q.size()), 67'h0);
      check_output("result_queue_empty", 67'(res_q.size()), 67'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- MemReadM  in  1  MEM-stage instruction is a load
- MemWriteM  in  1  MEM-stage instruction is a store
- MemSizeM  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- MemSignedM  in  1  sign-extend load result (lb/lh); 0 = zero-extend (lbu/lhu)
- AddrM  in  32  byte address (EX result latched into MEM)
- WriteDataM  in  32  store data, right-aligned
- StallM  in  1  pipeline holds MEM stage this cycle for a reason other than this block
- ReadDataM  out  32  extended load data presented to MEM/WB register
- StallReqM  out  1  request to stall IF..MEM
- AdelM  out  1  misaligned load
- AdesM  out  1  misaligned store
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  00/01/10 = 1/2/4 bytes
- data_addr  out  32  bus byte address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  bus accepted request this cycle
- data_rdata  in  32  bus read data, valid with data_data_ok
- data_data_ok  in  1  bus transfer complete this cycle
REQ-002 SHALL be clocked by clk only; rst is asynchronous and active-low.

Function
REQ-003 Access pending = (MemReadM|MemWriteM) & aligned; MemReadM and MemWriteM both high SHALL be treated as a store.
REQ-004 Misaligned: halfword with AddrM[0]=1, or word with AddrM[1:0]!=00; AdelM=MemReadM&misaligned, AdesM=MemWriteM&misaligned, both combinational; no bus request, StallReqM=0.
REQ-005 FSM states IDLE, REQ, WAIT, DONE.
REQ-006 IDLE: access pending -> capture wr, size, AddrM, replicated wdata into request registers, StallReqM=1 combinationally, next REQ; else stay, StallReqM=0.
REQ-007 REQ: data_req=1, data_wr/size/addr/wdata from request registers, held stable until data_addr_ok; StallReqM=1.
REQ-008 REQ with data_addr_ok & data_data_ok same cycle -> capture result, next DONE; data_addr_ok alone -> WAIT.
REQ-009 WAIT: data_req=0, StallReqM=1; data_data_ok -> capture result, next DONE.
REQ-010 DONE: StallReqM=0, ReadDataM = captured result; StallM=1 -> stay DONE (no re-issue); StallM=0 -> IDLE.
REQ-011 Minimum latency IDLE->DONE 2 cycles (addr_ok and data_ok in the first REQ cycle); instruction leaves MEM at the end of DONE.
REQ-012 Store lane replication: byte -> {4{b[7:0]}}, half -> {2{h[15:0]}}, word unchanged.
REQ-013 Load extraction: byte lane AddrM[1:0] (00 -> bits 7:0 ... 11 -> bits 31:24); half lane AddrM[1] (0 -> 15:0, 1 -> 31:16); word unchanged; extend to 32 bits per MemSignedM.
REQ-014 For stores, captured result SHALL be 0.
REQ-015 ReadDataM SHALL hold its last captured value in all states except when updated on data_data_ok.
REQ-016 data_data_ok or data_addr_ok outside the state expecting it SHALL be ignored.

Reset
REQ-017 rst low SHALL immediately force IDLE, data_req=0, ReadDataM=0, request registers 0; StallReqM=0 unless access pending.
REQ-018 Reset mid-transaction (REQ or WAIT) SHALL abandon it; a later data_data_ok is ignored per REQ-016.

Verification
REQ-019 lw AddrM=0x100, addr_ok+data_ok in first REQ cycle, rdata=0x12345678 -> data_req high 1 cycle, size=10, ReadDataM=0x12345678 in DONE, StallReqM high exactly 2 cycles.
REQ-020 lb AddrM=0x103, signed, rdata=0x80FFFFFF -> ReadDataM=0xFFFFFF80; same with lbu -> 0x00000080.
REQ-021 sh AddrM=0x202, WriteDataM=0xAAAABEEF, addr_ok delayed 3 cycles, data_ok 2 cycles later -> data_req held 4 cycles, addr/size/wdata=0x202/01/0xBEEFBEEF stable throughout, data_wr=1, StallReqM high 7 cycles.
REQ-022 lw AddrM=0x102 -> AdelM=1, data_req=0, StallReqM=0; sw AddrM=0x101 -> AdesM=1.
REQ-023 StallM=1 for 3 cycles in DONE -> no new data_req, ReadDataM stable; StallM=0 -> IDLE.
REQ-024 rst low during WAIT, data_data_ok after release -> state IDLE, ReadDataM=0, no DONE.
